add_sub_sat_pipe: RTL and testbench

Parametrised, pipelined saturating add/subtract/accumulate unit with a valid/ready stream interface on input and output. It is the next-generation arithmetic block for the datapath: it generalises the 16-bit combinational saturating adder/subtractor to any operand width. It adds a saturating accumulator, per-result and sticky saturation flags, and backpressure so it can sit between the register-read stage and the writeback buffer.

---
 rtl/add_sub_sat_pipe_pkg.sv | 22 ++
 rtl/add_sub_sat_pipe_sat_clamp.sv | 33 +++
 rtl/add_sub_sat_pipe.sv | 177 +++++++++++++++++
 tb/tb_add_sub_sat_pipe.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_sub_sat_pipe_pkg.sv
// Shared definitions for the saturating add/sub/accumulate pipeline:
// operation encodings and the signed range limits as functions of width.
package add_sub_sat_pkg;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_ACC  = 2'd2;
  localparam logic [1:0] OP_LOAD = 2'd3;

  // Largest positive two's complement value of the given width, as a bit
  // pattern in the low 'width' bits (2^(width-1) - 1).
  function automatic logic [63:0] sat_max(input int width);
    sat_max = (64'd1 << (width - 32'sd1)) - 64'd1;
  endfunction

  // Most negative two's complement value of the given width, as a bit
  // pattern in the low 'width' bits (-2^(width-1)).
  function automatic logic [63:0] sat_min(input int width);
    sat_min = 64'd1 << (width - 32'sd1);
  endfunction

endpackage

// File: rtl/add_sub_sat_pipe_sat_clamp.sv
// Combinational clamp of a WIDTH+1 bit signed value into WIDTH bits.
// Overflow shows up as disagreement between the two top bits; the top bit
// then tells which rail to clamp to.
module sat_clamp #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   i_sum,
  output logic [WIDTH-1:0] o_res,
  output logic             o_sat
);
  import add_sub_sat_pkg::*;

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(sat_min(WIDTH));

  // Select the in-range value or the saturation rail
  always_comb begin
    o_res = i_sum[WIDTH-1:0];
    o_sat = 1'b0;
    if (i_sum[WIDTH] != i_sum[WIDTH-1]) begin
      o_sat = 1'b1;
      if (i_sum[WIDTH]) begin
        o_res = MIN_V;
      end else begin
        o_res = MAX_V;
      end
    end else begin
      o_res = i_sum[WIDTH-1:0];
      o_sat = 1'b0;
    end
  end

endmodule

// File: rtl/add_sub_sat_pipe.sv
// Two-stage saturating add/sub/accumulate unit with valid/ready on both
// sides. The accumulator updates at accept so back-to-back ACC ops never
// stall; S1 carries the raw sum (or the already-clamped acc result) and S2
// holds the final clamped value that drives the outputs.
module add_sub_sat_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [1:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] c_out,
  output logic             sat_out,
  output logic [WIDTH-1:0] acc_out,
  input  logic             clr_sticky_in,
  output logic             sat_sticky_out
);
  import add_sub_sat_pkg::*;

  // Stage and state registers
  logic             r_s1_valid;
  logic [WIDTH:0]   r_s1_val;
  logic             r_s1_sat;
  logic [1:0]       r_s1_op;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_c;
  logic             r_s2_sat;
  logic [WIDTH-1:0] r_acc;
  logic             r_sticky;

  // Datapath wires
  logic [WIDTH:0]   w_a_ext;
  logic [WIDTH:0]   w_b_ext;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_acc_sum;
  logic [WIDTH-1:0] w_acc_res;
  logic             w_acc_sat;
  logic [WIDTH:0]   w_s1_val_next;
  logic             w_s1_sat_next;
  logic [WIDTH-1:0] w_s2_c_next;
  logic             w_clamp_sat;
  logic             w_s2_sat_next;
  logic             w_accept;
  logic             w_s2_load;
  logic             w_acc_op;

  assign w_a_ext   = {a_in[WIDTH-1], a_in};
  assign w_b_ext   = {b_in[WIDTH-1], b_in};
  assign w_sum     = w_a_ext + w_b_ext;
  // Subtraction as a + ~b + 1 in WIDTH+1 bits keeps b = MIN exact.
  assign w_diff    = w_a_ext + ~w_b_ext + {{WIDTH{1'b0}}, 1'b1};
  assign w_acc_sum = {r_acc[WIDTH-1], r_acc} + w_a_ext;

  assign ready_out = !rst_in && (!r_s1_valid || !r_s2_valid || ready_in);
  assign w_accept  = valid_in && ready_out;
  assign w_s2_load = r_s1_valid && (!r_s2_valid || ready_in);
  assign w_acc_op  = (r_s1_op == OP_ACC) || (r_s1_op == OP_LOAD);

  // Clamp on the accumulator path, resolved before S1
  sat_clamp #(.WIDTH(WIDTH)) u_clamp_acc (
    .i_sum (w_acc_sum),
    .o_res (w_acc_res),
    .o_sat (w_acc_sat)
  );

  // Clamp at the S1 to S2 boundary
  sat_clamp #(.WIDTH(WIDTH)) u_clamp_s2 (
    .i_sum (r_s1_val),
    .o_res (w_s2_c_next),
    .o_sat (w_clamp_sat)
  );

  // Choose the value and precomputed flag that S1 captures for each op
  always_comb begin
    w_s1_val_next = w_sum;
    w_s1_sat_next = 1'b0;
    case (op_in)
      OP_ADD: begin
        w_s1_val_next = w_sum;
        w_s1_sat_next = 1'b0;
      end
      OP_SUB: begin
        w_s1_val_next = w_diff;
        w_s1_sat_next = 1'b0;
      end
      OP_ACC: begin
        w_s1_val_next = {w_acc_res[WIDTH-1], w_acc_res};
        w_s1_sat_next = w_acc_sat;
      end
      OP_LOAD: begin
        w_s1_val_next = w_a_ext;
        w_s1_sat_next = 1'b0;
      end
      default: begin
        w_s1_val_next = w_sum;
        w_s1_sat_next = 1'b0;
      end
    endcase
  end

  // Acc ops already know their flag; add/sub take it from the clamp
  always_comb begin
    w_s2_sat_next = w_clamp_sat;
    if (w_acc_op) begin
      w_s2_sat_next = r_s1_sat;
    end else begin
      w_s2_sat_next = w_clamp_sat;
    end
  end

  // Stage 1: capture operation on accept, empty when it moves to S2
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_s1_valid <= 1'b0;
      r_s1_val   <= '0;
      r_s1_sat   <= 1'b0;
      r_s1_op    <= OP_ADD;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_val   <= w_s1_val_next;
      r_s1_sat   <= w_s1_sat_next;
      r_s1_op    <= op_in;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: clamped result, held stable while downstream stalls
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_s2_valid <= 1'b0;
      r_s2_c     <= '0;
      r_s2_sat   <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= 1'b1;
      r_s2_c     <= w_s2_c_next;
      r_s2_sat   <= w_s2_sat_next;
    end else if (ready_in) begin
      r_s2_valid <= 1'b0;
    end
  end

  // Accumulator updates at accept for ACC and LOAD only
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_acc <= '0;
    end else if (w_accept && (op_in == OP_ACC)) begin
      r_acc <= w_acc_res;
    end else if (w_accept && (op_in == OP_LOAD)) begin
      r_acc <= a_in;
    end
  end

  // Sticky saturation flag; a new saturated result beats a clear
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_sticky <= 1'b0;
    end else if (w_s2_load && w_s2_sat_next) begin
      r_sticky <= 1'b1;
    end else if (clr_sticky_in) begin
      r_sticky <= 1'b0;
    end
  end

  assign valid_out      = r_s2_valid;
  assign c_out          = r_s2_c;
  assign sat_out        = r_s2_sat;
  assign acc_out        = r_acc;
  assign sat_sticky_out = r_sticky;

endmodule

// File: tb/tb_add_sub_sat_pipe.sv
// Self-checking bench for add_sub_sat_pipe: directed cases from the test
// plan plus randomized streams checked against an integer reference model.
module tb_add_sub_sat_pipe;

  localparam longint MAXV = 64'sd32767;
  localparam longint MINV = -64'sd32768;

  logic        clk;
  logic        rst;
  logic        valid_in, ready_out, valid_out, ready_in, sat_out;
  logic        clr_sticky, sat_sticky;
  logic [1:0]  op_in;
  logic [15:0] a_in, b_in, c_out, acc_out;

  logic        valid8, ready_out8, valid_out8, sat8, sticky8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, c8, acc8;

  int          n_cmp = 0;
  int          n_err = 0;
  longint      m_acc = 0;
  longint      exp_c_q[$];
  bit          exp_s_q[$];
  bit          m_any_sat = 1'b0;

  add_sub_sat_pipe #(.WIDTH(16)) u_dut (
    .clk_in(clk), .rst_in(rst), .valid_in(valid_in), .ready_out(ready_out),
    .op_in(op_in), .a_in(a_in), .b_in(b_in), .valid_out(valid_out),
    .ready_in(ready_in), .c_out(c_out), .sat_out(sat_out), .acc_out(acc_out),
    .clr_sticky_in(clr_sticky), .sat_sticky_out(sat_sticky)
  );

  add_sub_sat_pipe #(.WIDTH(8)) u_dut8 (
    .clk_in(clk), .rst_in(rst), .valid_in(valid8), .ready_out(ready_out8),
    .op_in(op8), .a_in(a8), .b_in(b8), .valid_out(valid_out8),
    .ready_in(1'b1), .c_out(c8), .sat_out(sat8), .acc_out(acc8),
    .clr_sticky_in(1'b0), .sat_sticky_out(sticky8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint clampv(input longint v, output bit s);
    s = 1'b1;
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    s = 1'b0;
    return v;
  endfunction

  // Reference behaviour of one accepted operation
  task automatic model_accept(input logic [1:0] op, input longint a, input longint b);
    longint r;
    bit s;
    case (op)
      2'd0: r = clampv(a + b, s);
      2'd1: r = clampv(a - b, s);
      2'd2: begin r = clampv(m_acc + a, s); m_acc = r; end
      default: begin r = a; s = 1'b0; m_acc = a; end
    endcase
    exp_c_q.push_back(r);
    exp_s_q.push_back(s);
    if (s) m_any_sat = 1'b1;
  endtask

  function automatic logic [15:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'($urandom_range(0, 200)) - 16'd100;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
    n_cmp++; if (c_out !== 16'd0) begin n_err++; $display("FAIL reset_c_out: got %0d want 0", c_out); end
    n_cmp++; if (sat_out !== 1'b0) begin n_err++; $display("FAIL reset_sat_out: got %b want 0", sat_out); end
    n_cmp++; if (acc_out !== 16'd0) begin n_err++; $display("FAIL reset_acc_out: got %0d want 0", acc_out); end
    n_cmp++; if (sat_sticky !== 1'b0) begin n_err++; $display("FAIL reset_sticky: got %b want 0", sat_sticky); end
    n_cmp++; if (ready_out !== 1'b0) begin n_err++; $display("FAIL reset_ready_out: got %b want 0", ready_out); end
    rst = 1'b0;
    #1;
    n_cmp++; if (ready_out !== 1'b1) begin n_err++; $display("FAIL release_ready_out: got %b want 1", ready_out); end
    m_acc = 0;
  endtask

  task automatic test_directed();
    logic [1:0] t_op [4] = '{2'd0, 2'd1, 2'd1, 2'd1};
    longint t_a [4] = '{32767, -32768, 0, 100};
    longint t_b [4] = '{1, 1, -32768, -50};
    longint t_c [4] = '{32767, -32768, 32767, 150};
    bit     t_s [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1; op_in = t_op[i]; a_in = 16'(t_a[i]); b_in = 16'(t_b[i]);
      #1;
      n_cmp++; if (ready_out !== 1'b1) begin n_err++; $display("FAIL dir%0d_ready: got %b want 1", i, ready_out); end
      @(posedge clk); #1;
      valid_in = 1'b0;
      n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL dir%0d_early_valid: got %b want 0", i, valid_out); end
      @(posedge clk); #1;
      n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL dir%0d_valid: got %b want 1", i, valid_out); end
      n_cmp++; if ($signed(c_out) !== 16'(t_c[i])) begin n_err++; $display("FAIL dir%0d_c: got %0d want %0d", i, $signed(c_out), t_c[i]); end
      n_cmp++; if (sat_out !== t_s[i]) begin n_err++; $display("FAIL dir%0d_sat: got %b want %b", i, sat_out, t_s[i]); end
      if (i == 0) begin
        n_cmp++; if (sat_sticky !== 1'b1) begin n_err++; $display("FAIL dir0_sticky: got %b want 1", sat_sticky); end
      end
      @(posedge clk); #1;
      n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL dir%0d_drained: got %b want 0", i, valid_out); end
    end
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    n_cmp++; if (sat_sticky !== 1'b0) begin n_err++; $display("FAIL dir_clear_sticky: got %b want 0", sat_sticky); end
  endtask

  task automatic test_acc();
    logic [1:0] t_op [3] = '{2'd3, 2'd2, 2'd2};
    logic [15:0] t_a [3] = '{16'd30000, 16'd2000, 16'd1000};
    logic [15:0] t_acc [3] = '{16'd30000, 16'd32000, 16'd32767};
    logic [15:0] t_c [3] = '{16'd30000, 16'd32000, 16'd32767};
    bit t_s [3] = '{1'b0, 1'b0, 1'b1};
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid_in = (i < 3);
      if (i < 3) begin op_in = t_op[i]; a_in = t_a[i]; b_in = 16'($urandom); end
      #1;
      if (i < 3) begin
        n_cmp++; if (ready_out !== 1'b1) begin n_err++; $display("FAIL acc%0d_ready: got %b want 1", i, ready_out); end
      end
      @(posedge clk); #1;
      if (i < 3) begin
        n_cmp++; if (acc_out !== t_acc[i]) begin n_err++; $display("FAIL acc%0d_acc_out: got %0d want %0d", i, acc_out, t_acc[i]); end
      end
      if (i > 0) begin
        n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL acc%0d_valid: got %b want 1", i, valid_out); end
        n_cmp++; if (c_out !== t_c[i-1]) begin n_err++; $display("FAIL acc%0d_c: got %0d want %0d", i, c_out, t_c[i-1]); end
        n_cmp++; if (sat_out !== t_s[i-1]) begin n_err++; $display("FAIL acc%0d_sat: got %b want %b", i, sat_out, t_s[i-1]); end
      end
    end
    valid_in = 1'b0;
    n_cmp++; if (acc_out !== 16'd32767) begin n_err++; $display("FAIL acc_final: got %0d want 32767", acc_out); end
    @(posedge clk); #1;
    m_acc = MAXV;
  endtask

  task automatic test_sticky();
    ready_in = 1'b1;
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    valid_in = 1'b1; op_in = 2'd0; a_in = 16'h7FFF; b_in = 16'd1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (sat_sticky !== 1'b1) begin n_err++; $display("FAIL sticky_set_wins: got %b want 1", sat_sticky); end
    n_cmp++; if (sat_out !== 1'b1) begin n_err++; $display("FAIL sticky_sat_out: got %b want 1", sat_out); end
    @(posedge clk); #1;
    n_cmp++; if (sat_sticky !== 1'b0) begin n_err++; $display("FAIL sticky_cleared: got %b want 0", sat_sticky); end
    clr_sticky = 1'b0;
  endtask

  // Streams n ops through the unit; add_only uses the 1,0,0 ready pattern
  task automatic test_back_to_back(input int n, input bit add_only);
    int sent = 0, got = 0, inflight = 0, cyc = 0;
    bit prev_stall = 1'b0, acc_fl, hs, exp_ready;
    logic [15:0] prev_c = 16'd0;
    logic prev_s = 1'b0;
    longint ec;
    bit es;
    ready_in = 1'b1;
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    m_any_sat = 1'b0;
    while (got < n && cyc < 2000) begin
      if (sent < n) begin
        valid_in = add_only ? 1'b1 : ($urandom_range(0, 3) != 0);
        op_in = add_only ? 2'd0 : 2'($urandom_range(0, 3));
        a_in = rnd_operand();
        b_in = rnd_operand();
      end else begin
        valid_in = 1'b0;
      end
      ready_in = add_only ? (cyc % 3 == 0) : ($urandom_range(0, 9) < 7);
      #1;
      exp_ready = !(inflight == 2 && !ready_in);
      n_cmp++; if (ready_out !== exp_ready) begin n_err++; $display("FAIL stream_ready cyc%0d: got %b want %b", cyc, ready_out, exp_ready); end
      n_cmp++; if (acc_out !== 16'(m_acc)) begin n_err++; $display("FAIL stream_acc_out cyc%0d: got %0d want %0d", cyc, $signed(acc_out), m_acc); end
      if (prev_stall) begin
        n_cmp++; if (valid_out !== 1'b1 || c_out !== prev_c || sat_out !== prev_s) begin
          n_err++; $display("FAIL stream_hold cyc%0d: got %b/%0d/%b want 1/%0d/%b", cyc, valid_out, c_out, sat_out, prev_c, prev_s);
        end
      end
      acc_fl = valid_in && ready_out;
      hs = valid_out && ready_in;
      if (hs) begin
        n_cmp++;
        if (exp_c_q.size() == 0) begin
          n_err++; $display("FAIL stream_extra cyc%0d: got result %0d want none", cyc, $signed(c_out));
        end else begin
          ec = exp_c_q.pop_front();
          es = exp_s_q.pop_front();
          if ($signed(c_out) !== 16'(ec) || sat_out !== es) begin
            n_err++; $display("FAIL stream_result %0d: got %0d/%b want %0d/%b", got, $signed(c_out), sat_out, ec, es);
          end
        end
        got++;
      end
      prev_stall = valid_out && !ready_in;
      prev_c = c_out;
      prev_s = sat_out;
      @(posedge clk); #1;
      if (acc_fl) begin
        model_accept(op_in, longint'($signed(a_in)), longint'($signed(b_in)));
        sent++;
        inflight++;
      end
      if (hs) inflight--;
      cyc++;
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    n_cmp++; if (got != n) begin n_err++; $display("FAIL stream_timeout: got %0d results want %0d", got, n); end
    n_cmp++; if (sat_sticky !== m_any_sat) begin n_err++; $display("FAIL stream_sticky: got %b want %b", sat_sticky, m_any_sat); end
  endtask

  task automatic test_reset_midop();
    ready_in = 1'b0;
    valid_in = 1'b1; op_in = 2'd0; a_in = 16'h7FFF; b_in = 16'd1;
    @(posedge clk); #1;
    op_in = 2'd3; a_in = 16'd500;
    @(posedge clk); #1;
    valid_in = 1'b0;
    #1;
    n_cmp++; if (ready_out !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", ready_out); end
    n_cmp++; if (acc_out !== 16'd500) begin n_err++; $display("FAIL full_acc: got %0d want 500", acc_out); end
    n_cmp++; if (valid_out !== 1'b1 || sat_sticky !== 1'b1) begin n_err++; $display("FAIL full_state: got %b/%b want 1/1", valid_out, sat_sticky); end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL async_valid: got %b want 0", valid_out); end
    n_cmp++; if (acc_out !== 16'd0) begin n_err++; $display("FAIL async_acc: got %0d want 0", acc_out); end
    n_cmp++; if (sat_sticky !== 1'b0) begin n_err++; $display("FAIL async_sticky: got %b want 0", sat_sticky); end
    n_cmp++; if (ready_out !== 1'b0) begin n_err++; $display("FAIL async_ready: got %b want 0", ready_out); end
    @(posedge clk); #1;
    rst = 1'b0;
    ready_in = 1'b1;
    m_acc = 0;
    exp_c_q.delete();
    exp_s_q.delete();
    valid_in = 1'b1; op_in = 2'd1; a_in = 16'd100; b_in = -16'sd50;
    #1;
    n_cmp++; if (ready_out !== 1'b1) begin n_err++; $display("FAIL post_rst_ready: got %b want 1", ready_out); end
    @(posedge clk); #1;
    valid_in = 1'b0;
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL post_rst_early: got %b want 0", valid_out); end
    @(posedge clk); #1;
    n_cmp++; if (valid_out !== 1'b1 || c_out !== 16'd150 || sat_out !== 1'b0) begin
      n_err++; $display("FAIL post_rst_result: got %b/%0d/%b want 1/150/0", valid_out, c_out, sat_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_width8();
    valid8 = 1'b1; op8 = 2'd0; a8 = 8'd127; b8 = 8'd127;
    #1;
    n_cmp++; if (ready_out8 !== 1'b1) begin n_err++; $display("FAIL w8_ready: got %b want 1", ready_out8); end
    @(posedge clk); #1;
    valid8 = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (valid_out8 !== 1'b1 || c8 !== 8'd127 || sat8 !== 1'b1) begin
      n_err++; $display("FAIL w8_add: got %b/%0d/%b want 1/127/1", valid_out8, c8, sat8);
    end
    n_cmp++; if (sticky8 !== 1'b1 || acc8 !== 8'd0) begin n_err++; $display("FAIL w8_state: got %b/%0d want 1/0", sticky8, acc8); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; ready_in = 1'b1; op_in = 2'd0;
    a_in = 16'd0; b_in = 16'd0; clr_sticky = 1'b0;
    valid8 = 1'b0; op8 = 2'd0; a8 = 8'd0; b8 = 8'd0;
    test_reset();
    test_directed();
    test_acc();
    test_sticky();
    test_back_to_back(8, 1'b1);
    test_back_to_back(60, 1'b0);
    test_reset_midop();
    test_width8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
